// File: rtl/graph_pkg.sv
// Shared types for the graph pipeline: event and edge payloads, the
// convolution sweep length, and the admission scheduler's state and
// FIFO entry types.
package graph_pkg;

  localparam int unsigned MAX_EDGES      = 4;
  localparam int unsigned MEMORY_OPS_NUM = 15;
  localparam int unsigned COORD_W        = 8;
  localparam int unsigned TS_W           = 16;
  localparam int unsigned NBR_W          = 7;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               polarity;
    logic [TS_W-1:0]    ts;
  } event_type;

  typedef struct packed {
    logic             valid;
    logic [NBR_W-1:0] nbr;
  } edge_type;

  typedef enum logic [0:0] {
    CS_IDLE = 1'b0,
    CS_WAIT = 1'b1
  } conv_sched_state_t;

  typedef struct packed {
    event_type                  ev;
    edge_type [MAX_EDGES-1:0]   edges;
  } conv_sched_entry_t;

endpackage

// File: rtl/conv_sched_fifo.sv
// Synchronous FIFO of scheduler entries. Registered read path (no
// fall-through): an entry pushed on one edge is visible at the head
// from the following cycle.
//   clk, reset   : clock, synchronous active-low reset
//   push, wdata  : write request and entry (ignored when full or flushing)
//   pop, rdata   : read request and head entry (ignored when empty or flushing)
//   flush        : clears the FIFO on this edge
//   full, empty, level : occupancy status
module conv_sched_fifo
  import graph_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  conv_sched_entry_t      wdata,
  output conv_sched_entry_t      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  conv_sched_entry_t mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; flush takes priority over any push/pop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/conv_event_scheduler.sv
// Admission controller in front of the async graph-convolution stage.
// Buffers events with their edge vectors, issues them one at a time with
// issue pulses at least ISSUE_INTERVAL cycles apart, and bounds the number
// of issued-but-not-completed events to MAX_INFLIGHT.
// Optional build macro CONV_SCHED_DROP_EN: s_ready held high outside reset
// and flush, pushes into a full FIFO are discarded and counted on drop_cnt.
//   clk, reset          : clock, synchronous active-low reset
//   s_event, s_edges    : upstream event/edges, s_event.valid requests
//   s_ready             : combinational accept qualifier
//   flush               : clears buffered events
//   conv_event/edges    : issued event, .valid is a 1-cycle pulse
//   conv_done           : completion pulse from the convolution
//   fifo_level, inflight, issued_cnt, completed_cnt : status
//   err_underflow       : sticky, completion seen with nothing in flight
//   drop_cnt            : discarded pushes (CONV_SCHED_DROP_EN only)
module conv_event_scheduler
  import graph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ISSUE_INTERVAL = MEMORY_OPS_NUM,
  parameter int unsigned MAX_INFLIGHT   = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  event_type                     s_event,
  input  edge_type [MAX_EDGES-1:0]      s_edges,
  output logic                          s_ready,
  input  logic                          flush,
  output event_type                     conv_event,
  output edge_type [MAX_EDGES-1:0]      conv_edges,
  input  logic                          conv_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic [CNT_WIDTH-1:0]          issued_cnt,
  output logic [CNT_WIDTH-1:0]          completed_cnt,
  output logic                          err_underflow
`ifdef CONV_SCHED_DROP_EN
  ,
  output logic [CNT_WIDTH-1:0]          drop_cnt
`endif
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned GW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

  localparam logic [0:0]    ST_IDLE   = 1'(CS_IDLE);
  localparam logic [0:0]    ST_WAIT   = 1'(CS_WAIT);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(ISSUE_INTERVAL - 1);
  localparam bit            SKIP_WAIT = (ISSUE_INTERVAL <= 1);

  logic [0:0]        state;
  logic [0:0]        state_nx;
  logic [GW-1:0]     gap;
  logic [GW-1:0]     gap_nx;
  logic              issue;
  logic              can_issue;
  logic              slot_free;
  logic              accept;
  logic              push;
  logic              dec;
  logic              full;
  logic              empty;
  conv_sched_entry_t head;
  conv_sched_entry_t wentry;

  assign slot_free = (inflight < IW'(MAX_INFLIGHT));
  assign can_issue = !empty && slot_free && !flush;

`ifdef CONV_SCHED_DROP_EN
  assign s_ready = reset && !flush;
`else
  assign s_ready = reset && !full && !flush;
`endif

  assign accept = s_event.valid && s_ready;
  assign push   = accept && !full;
  // Completion only retires an event when one is actually outstanding.
  assign dec    = conv_done && (inflight != '0);

  // Stored valid marks a live entry; it is always set on write, so the
  // head entry can be forwarded as-is on issue.
  always_comb begin
    wentry          = '{ev: s_event, edges: s_edges};
    wentry.ev.valid = 1'b1;
  end

  conv_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .flush (flush),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      gap   <= '0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
    end
  end

  // Next-state logic. The last WAIT cycle (gap==0) runs the issue check
  // itself so back-to-back pulses land exactly ISSUE_INTERVAL apart.
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    issue    = 1'b0;
    if (state == ST_IDLE) begin
      issue = can_issue;
    end else if (gap == '0) begin
      issue    = can_issue;
      state_nx = ST_IDLE;
    end else begin
      gap_nx = gap - GW'(1);
    end
    if (issue) begin
      gap_nx   = GAP_LOAD;
      state_nx = SKIP_WAIT ? ST_IDLE : ST_WAIT;
    end
  end

  // Issue outputs: payload is held between pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      conv_event <= '0;
      conv_edges <= '0;
    end else if (issue) begin
      conv_event <= head.ev;
      conv_edges <= head.edges;
    end else begin
      conv_event.valid <= 1'b0;
    end
  end

  // In-flight tracking, statistics and underflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight      <= '0;
      issued_cnt    <= '0;
      completed_cnt <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({issue, dec})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
      if (issue)                        issued_cnt    <= issued_cnt + CNT_WIDTH'(1);
      if (conv_done)                    completed_cnt <= completed_cnt + CNT_WIDTH'(1);
      if (conv_done && inflight == '0)  err_underflow <= 1'b1;
    end
  end

`ifdef CONV_SCHED_DROP_EN
  // Count requests that arrive while the FIFO is full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (accept && full) begin
      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_event_scheduler.sv
// Directed bench for conv_event_scheduler (default parameters:
// FIFO_DEPTH=8, ISSUE_INTERVAL=15, MAX_INFLIGHT=2, CNT_WIDTH=16).
module tb_conv_event_scheduler;
  import graph_pkg::*;

  localparam int unsigned CW = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     conv_done;
  event_type                s_event;
  event_type                conv_event;
  edge_type [MAX_EDGES-1:0] s_edges;
  edge_type [MAX_EDGES-1:0] conv_edges;
  logic                     s_ready;
  logic                     err_underflow;
  logic [3:0]               fifo_level;
  logic [1:0]               inflight;
  logic [CW-1:0]            issued_cnt;
  logic [CW-1:0]            completed_cnt;
`ifdef CONV_SCHED_DROP_EN
  logic [CW-1:0]            drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int issue_q[$];
  int xs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every issue pulse with its cycle number and event x coordinate.
  always @(negedge clk) begin
    if (conv_event.valid === 1'b1) begin
      issue_q.push_back(cyc);
      xs_q.push_back(int'(conv_event.x));
    end
  end

  conv_event_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .s_event       (s_event),
    .s_edges       (s_edges),
    .s_ready       (s_ready),
    .flush         (flush),
    .conv_event    (conv_event),
    .conv_edges    (conv_edges),
    .conv_done     (conv_done),
    .fifo_level    (fifo_level),
    .inflight      (inflight),
    .issued_cnt    (issued_cnt),
    .completed_cnt (completed_cnt),
    .err_underflow (err_underflow)
`ifdef CONV_SCHED_DROP_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  function automatic event_type mk_ev(input int i);
    event_type e;
    e.valid    = 1'b1;
    e.x        = 8'(i);
    e.y        = 8'(i + 3);
    e.polarity = i[0];
    e.ts       = 16'(i * 7);
    return e;
  endfunction

  function automatic logic [31:0] mk_edges(input int i);
    edge_type [MAX_EDGES-1:0] e;
    for (int k = 0; k < int'(MAX_EDGES); k++) begin
      e[k].valid = 1'b1;
      e[k].nbr   = 7'(i + k);
    end
    return 32'(e);
  endfunction

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s", tag);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    event_type ev_h;
    int        n;
    int        sz;
    bit        saw_stall;
    bit        all_ready;

    reset     = 1'b0;
    flush     = 1'b0;
    conv_done = 1'b0;
    s_event   = '0;
    s_edges   = '0;
    repeat (2) step();

    // Reset values
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_conv_event", 64'(conv_event), 64'(0));
    chk("rst_conv_edges", 64'(conv_edges), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_issued", 64'(issued_cnt), 64'(0));
    chk("rst_completed", 64'(completed_cnt), 64'(0));
    chk("rst_err", 64'(err_underflow), 64'(0));

    reset = 1'b1;
    #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'(1));

    // Single event: issue pulse in the cycle after the edge following accept
    s_event = mk_ev(1);
    s_edges = mk_edges(1);
    step();
    s_event = '0;
    s_edges = '0;
    chk("t1_level_after_accept", 64'(fifo_level), 64'(1));
    chk("t1_no_fallthrough", 64'(conv_event.valid), 64'(0));
    step();
    checks++;
    if (conv_event !== mk_ev(1)) fail("t1_issue_event");
    checks++;
    if (conv_edges !== mk_edges(1)) fail("t1_issue_edges");
    checks++;
    if (issued_cnt !== 16'd1) fail("t1_issued_cnt");
    checks++;
    if (inflight !== 2'd1) fail("t1_inflight");
    chk("t1_level_after_issue", 64'(fifo_level), 64'(0));
    step();
    chk("t1_pulse_one_cycle", 64'(conv_event.valid), 64'(0));
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    checks++;
    if (inflight !== 2'd0) fail("t1_inflight_done");
    checks++;
    if (completed_cnt !== 16'd1) fail("t1_completed_cnt");
    repeat (16) step();

`ifdef CONV_SCHED_DROP_EN
    // Drop mode: reach MAX_INFLIGHT, then overfill the FIFO
    s_event = mk_ev(50); s_edges = mk_edges(50); step();
    s_event = mk_ev(51); s_edges = mk_edges(51); step();
    s_event = '0; s_edges = '0;
    repeat (20) step();
    chk("d_inflight_stalled", 64'(inflight), 64'(2));
    all_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_event = mk_ev(60 + i);
      s_edges = mk_edges(60 + i);
      all_ready &= s_ready;
      step();
    end
    s_event = '0; s_edges = '0;
    chk("d_s_ready_held", 64'(all_ready), 64'(1));
    chk("d_level", 64'(fifo_level), 64'(8));
    chk("d_drop_cnt", 64'(drop_cnt), 64'(4));
`else
    // Ten back-to-back events with no completions
    issue_q.delete();
    xs_q.delete();
    saw_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_event = mk_ev(10 + i);
      s_edges = mk_edges(10 + i);
      n = 0;
      while (!s_ready && n < 200) begin
        if (!saw_stall) begin
          saw_stall = 1'b1;
          chk("t2_level_at_stall", 64'(fifo_level), 64'(8));
        end
        step();
        n++;
      end
      chk("t2_accept_bound", 64'(n < 200), 64'(1));
      step();
    end
    s_event = '0; s_edges = '0;
    chk("t2_stalled", 64'(saw_stall), 64'(1));
    chk("t2_level_full", 64'(fifo_level), 64'(8));
    chk("t2_s_ready_low", 64'(s_ready), 64'(0));
    repeat (20) step();
    chk("t2_two_issues", 64'(issue_q.size()), 64'(2));
    if (issue_q.size() == 2) chk("t2_first_gap", 64'(issue_q[1] - issue_q[0]), 64'(15));
    chk("t2_inflight_max", 64'(inflight), 64'(2));

    // One completion every 15 cycles releases the remaining eight
    for (int k = 0; k < 8; k++) begin
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      repeat (14) step();
    end
    chk("t2_ten_issues", 64'(issue_q.size()), 64'(10));
    if (issue_q.size() == 10) begin
      for (int j = 3; j < 10; j++) begin
        checks++;
        if (issue_q[j] - issue_q[j-1] != 15) fail("t2_spacing");
      end
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (xs_q[j] != 10 + j) fail("t2_order");
      end
    end
    chk("t2_level_drained", 64'(fifo_level), 64'(0));
    chk("t2_inflight_end", 64'(inflight), 64'(2));
    chk("t2_completed", 64'(completed_cnt), 64'(9));
    chk("t2_no_err", 64'(err_underflow), 64'(0));

    // Simultaneous issue and completion, then underflow
    repeat (20) step();
    conv_done = 1'b1; step(); conv_done = 1'b0;
    chk("t3_inflight_one", 64'(inflight), 64'(1));
    s_event = mk_ev(30); s_edges = mk_edges(30);
    step();
    s_event = '0; s_edges = '0;
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    chk("t3_issue_seen", 64'(conv_event.valid), 64'(1));
    chk("t3_inflight_held", 64'(inflight), 64'(1));
    chk("t3_issued", 64'(issued_cnt), 64'(12));
    conv_done = 1'b1; step(); conv_done = 1'b0;
    chk("t3_inflight_zero", 64'(inflight), 64'(0));
    chk("t3_err_clear", 64'(err_underflow), 64'(0));
    conv_done = 1'b1; step(); conv_done = 1'b0;
    chk("t3_err_set", 64'(err_underflow), 64'(1));
    chk("t3_inflight_floor", 64'(inflight), 64'(0));
    repeat (5) step();
    chk("t3_err_sticky", 64'(err_underflow), 64'(1));
    chk("t3_completed", 64'(completed_cnt), 64'(13));

    // Flush in WAIT with five buffered and a concurrent push
    repeat (20) step();
    for (int i = 0; i < 6; i++) begin
      s_event = mk_ev(20 + i);
      s_edges = mk_edges(20 + i);
      step();
    end
    chk("t4_level_before", 64'(fifo_level), 64'(5));
    s_event = mk_ev(26); s_edges = mk_edges(26);
    flush = 1'b1;
    #1;
    chk("t4_s_ready_flush", 64'(s_ready), 64'(0));
    step();
    flush = 1'b0;
    s_event = '0; s_edges = '0;
    ev_h = mk_ev(20);
    ev_h.valid = 1'b0;
    sz = issue_q.size();
    chk("t4_level_flushed", 64'(fifo_level), 64'(0));
    chk("t4_payload_held", 64'(conv_event), 64'(ev_h));
    chk("t4_inflight", 64'(inflight), 64'(1));
    repeat (8) step();
    chk("t4_payload_still", 64'(conv_event), 64'(ev_h));
    chk("t4_edges_held", 64'(conv_edges), 64'(mk_edges(20)));
    repeat (20) step();
    chk("t4_no_issue", 64'(issue_q.size()), 64'(sz));
    chk("t4_level_end", 64'(fifo_level), 64'(0));

    // Reset asserted mid-WAIT with four buffered
    for (int i = 0; i < 5; i++) begin
      s_event = mk_ev(40 + i);
      s_edges = mk_edges(40 + i);
      step();
    end
    chk("t5_level_before", 64'(fifo_level), 64'(4));
    chk("t5_inflight_before", 64'(inflight), 64'(2));
    s_event = mk_ev(45); s_edges = mk_edges(45);
    reset = 1'b0;
    #1;
    chk("t5_s_ready_in_reset", 64'(s_ready), 64'(0));
    step();
    s_event = '0; s_edges = '0;
    chk("t5_conv_event", 64'(conv_event), 64'(0));
    chk("t5_conv_edges", 64'(conv_edges), 64'(0));
    chk("t5_level", 64'(fifo_level), 64'(0));
    chk("t5_inflight", 64'(inflight), 64'(0));
    chk("t5_issued", 64'(issued_cnt), 64'(0));
    chk("t5_completed", 64'(completed_cnt), 64'(0));
    chk("t5_err", 64'(err_underflow), 64'(0));
    reset = 1'b1;
    sz = issue_q.size();
    repeat (20) step();
    chk("t5_no_issue_after", 64'(issue_q.size()), 64'(sz));
    chk("t5_s_ready_back", 64'(s_ready), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_event_scheduler.md
Name: conv_event_scheduler

Overview:
Admission controller in front of the async graph-convolution stage. It buffers incoming events and their edge vectors in a small FIFO. It issues them to the convolution one at a time, with issue pulses spaced so the convolution's MEMORY_OPS_NUM-cycle neighbour sweep is never restarted mid-event. It also tracks events in flight and limits their number, using the convolution's output valid as the completion signal.

Parameters:
FIFO_DEPTH, 8, entries of event+edges storage; power of 2, >=2
ISSUE_INTERVAL, graph_pkg::MEMORY_OPS_NUM, minimum cycles between consecutive issue pulses
MAX_INFLIGHT, 2, maximum issued-but-not-completed events
CNT_WIDTH, 16, width of the issued/completed statistics counters

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-low (reset==0 resets all state on the next posedge)
s_event  in  graph_pkg::event_type  upstream event; s_event.valid is the request
s_edges  in  graph_pkg::edge_type[MAX_EDGES]  edge vector accompanying s_event
s_ready  out  1  upstream may transfer when s_event.valid && s_ready
flush  in  1  synchronous FIFO clear
conv_event  out  graph_pkg::event_type  to convolution; .valid is a 1-cycle issue pulse
conv_edges  out  graph_pkg::edge_type[MAX_EDGES]  edges for the issued event
conv_done  in  1  convolution out_event.valid (one pulse per completed event)
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
inflight  out  $clog2(MAX_INFLIGHT)+1  issued minus completed
issued_cnt  out  CNT_WIDTH  total issues, wraps
completed_cnt  out  CNT_WIDTH  total conv_done pulses, wraps
err_underflow  out  1  sticky: conv_done seen while inflight==0

Behaviour:
- Reset values: s_ready=0 during reset, then 1 at the first cycle out of reset. conv_event all-zero, including valid=0. conv_edges=0. All counters, fifo_level, inflight and err_underflow are 0. FSM is in IDLE. FIFO contents are don't-care.
- Reset mid-operation drops the FIFO contents and the in-flight count. The convolution is assumed to be reset by the same source.
- s_ready is combinational: !full && !flush. Transfers are accepted only on edges with s_event.valid && s_ready; the .valid bit is not stored.
- FIFO is registered, with no fall-through. An event accepted on edge k can issue on edge k+1 at the earliest, so conv_event.valid is high in the cycle after edge k+1.
- Simultaneous push and pop when not full: both take effect, and the level is unchanged.
- FSM states:
  - IDLE: if !empty && inflight<MAX_INFLIGHT, pop the FIFO, register conv_event/conv_edges with valid=1, load gap=ISSUE_INTERVAL-1, go to WAIT.
  - WAIT: conv_event.valid=0 and the payload is held. Decrement gap. When gap==0, go to IDLE. The IDLE issue check runs in that same cycle, so issue pulses are exactly ISSUE_INTERVAL cycles apart under continuous load.
  - ISSUE_INTERVAL==1 is legal: WAIT is skipped and a pulse can be issued every cycle.
- inflight: +1 on issue and -1 on conv_done. Both in one cycle leaves it unchanged. conv_done with inflight==0 sets err_underflow and leaves inflight at 0.
- Counters wrap modulo 2^CNT_WIDTH.
- flush: empties the FIFO on that edge, and a push in the same cycle is ignored. An event already issued (in WAIT) completes normally. inflight is not cleared.

Optional Feature:
CONV_SCHED_DROP_EN
- Defined: s_ready is held at 1 (except during reset or flush). A push when the FIFO is full is discarded. Adds output drop_cnt (CNT_WIDTH, wraps), incremented per discarded event.
- Undefined: backpressure via s_ready as above, and no drop_cnt port.

Decomposition:
- graph_pkg already holds event_type, edge_type, MAX_EDGES and MEMORY_OPS_NUM.
- Add to graph_pkg:
  - conv_sched_state_t (IDLE, WAIT)
  - conv_sched_entry_t, a packed struct of event_type and edge_type[MAX_EDGES].
- One sub-module: conv_sched_fifo, a parameterised synchronous FIFO of conv_sched_entry_t with push/pop/flush/full/empty/level.

Test Plan:
- Single event p=1 after reset → conv_event.valid high 2 cycles after the accept edge; issued_cnt=1, inflight=1; a conv_done pulse → inflight=0, completed_cnt=1.
- 10 back-to-back events, FIFO_DEPTH=8, no conv_done, MAX_INFLIGHT=2 → exactly 2 issues 15 cycles apart; s_ready drops at 8 buffered (level=8); then pulse conv_done 8 times → remaining issues spaced exactly 15 cycles.
- conv_done and issue on the same edge with inflight=1 → inflight stays 1; conv_done with inflight=0 → err_underflow=1 and stays 1 until reset.
- flush with 5 buffered, asserted in WAIT together with a push → level=0, the push is ignored, and the current event's payload is held until WAIT ends.
- reset=0 asserted mid-WAIT with level=4 → next cycle all outputs are at reset values and no issue pulse follows.
- CONV_SCHED_DROP_EN defined, 12 events pushed while stalled at MAX_INFLIGHT → s_ready stays 1, level=8, drop_cnt=4.
